alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 113 +++++++++++
 tb/tb_alu_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// Each accepted request walks IDLE -> EXEC -> RESP and is held until its result is consumed.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [3:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [3:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             resp0_valid,
    output logic             resp1_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic [WIDTH-1:0] alu_rd1,
    output logic [WIDTH-1:0] alu_rd2,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_wd
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t           state_q, state_d;
    logic             prio_q, prio_d;
    logic             gnt_q, gnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             grant0, grant1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            prio_q   <= 1'b0;
            gnt_q    <= 1'b0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            gnt_q    <= gnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
        end
    end

    // A lone requester always wins; a tie goes to whichever side prio names.
    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        gnt_d       = gnt_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        resp0_valid = 1'b0;
        resp1_valid = 1'b0;
        grant0      = req0_valid && (!req1_valid || !prio_q);
        grant1      = req1_valid && (!req0_valid || prio_q);

        case (state_q)
            IDLE: begin
                req0_ready = grant0;
                req1_ready = grant1;
                if (grant0 || grant1) begin
                    gnt_d   = grant1;
                    op_d    = grant1 ? req1_op : req0_op;
                    a_d     = grant1 ? req1_a  : req0_a;
                    b_d     = grant1 ? req1_b  : req0_b;
                    prio_d  = !grant1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                result_d = alu_wd;
                state_d  = RESP;
            end
            RESP: begin
                resp0_valid = !gnt_q;
                resp1_valid = gnt_q;
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand registers only change on acceptance, so the ALU inputs stay quiet between operations.
    assign alu_rd1   = a_q;
    assign alu_rd2   = b_q;
    assign alu_op    = op_q;
    assign resp_data = result_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized bench for alu_arbiter against a transaction-level reference model.
module tb_alu_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req1_valid;
    logic [3:0]   req0_op, req1_op;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         req0_ready, req1_ready;
    logic         resp0_valid, resp1_valid;
    logic         resp_ready;
    logic [W-1:0] resp_data;
    logic [W-1:0] alu_rd1, alu_rd2;
    logic [3:0]   alu_op;
    logic [W-1:0] alu_wd;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: one in-flight operation, its age in cycles since acceptance.
    bit           m_busy;
    int           m_age;
    bit           m_owner;
    bit           m_prio;
    logic [3:0]   m_op;
    logic [W-1:0] m_a, m_b, m_res;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ready(req1_ready),
        .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
        .resp_ready(resp_ready), .resp_data(resp_data),
        .alu_rd1(alu_rd1), .alu_rd2(alu_rd2), .alu_op(alu_op), .alu_wd(alu_wd)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] alu_ref(input logic [3:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        case (op)
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b0100: return a ^ b;
            4'b0110: return a | b;
            4'b0111: return a & b;
            default: return a;
        endcase
    endfunction

    // The external ALU the arbiter feeds.
    always_comb alu_wd = alu_ref(alu_op, alu_rd1, alu_rd2);

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_age   = 0;
        m_owner = 1'b0;
        m_prio  = 1'b0;
        m_op    = '0;
        m_a     = '0;
        m_b     = '0;
        m_res   = '0;
    endtask

    task automatic drive(input logic v0, input logic [3:0] op0, input logic [W-1:0] a0,
                         input logic [W-1:0] b0, input logic v1, input logic [3:0] op1,
                         input logic [W-1:0] a1, input logic [W-1:0] b1, input logic rr);
        req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
        resp_ready = rr;
    endtask

    task automatic checkOutput(input string tag, output bit e_r0, output bit e_r1);
        bit in_resp;
        e_r0    = !m_busy && req0_valid && (!req1_valid || !m_prio);
        e_r1    = !m_busy && req1_valid && (!req0_valid || m_prio);
        in_resp = m_busy && (m_age >= 2);
        chk({tag, ".req0_ready"},  W'(req0_ready),  W'(e_r0));
        chk({tag, ".req1_ready"},  W'(req1_ready),  W'(e_r1));
        chk({tag, ".resp0_valid"}, W'(resp0_valid), W'(in_resp && !m_owner));
        chk({tag, ".resp1_valid"}, W'(resp1_valid), W'(in_resp && m_owner));
        if (in_resp) chk({tag, ".resp_data"}, resp_data, m_res);
        chk({tag, ".alu_rd1"}, alu_rd1, m_a);
        chk({tag, ".alu_rd2"}, alu_rd2, m_b);
        chk({tag, ".alu_op"},  W'(alu_op), W'(m_op));
    endtask

    // One clock: check at the falling edge, advance the model at the rising edge.
    task automatic step(input string tag);
        bit e_r0, e_r1;
        @(negedge clk);
        checkOutput(tag, e_r0, e_r1);
        @(posedge clk);
        if (m_busy) begin
            if (m_age >= 2 && resp_ready) m_busy = 1'b0;
            else if (m_age < 2) m_age++;
        end else if (e_r0 || e_r1) begin
            m_busy  = 1'b1;
            m_age   = 1;
            m_owner = e_r1;
            m_op    = e_r1 ? req1_op : req0_op;
            m_a     = e_r1 ? req1_a  : req0_a;
            m_b     = e_r1 ? req1_b  : req0_b;
            m_res   = alu_ref(m_op, m_a, m_b);
            m_prio  = !e_r1;
        end
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".req0_ready"},  W'(req0_ready),  '0);
        chk({tag, ".req1_ready"},  W'(req1_ready),  '0);
        chk({tag, ".resp0_valid"}, W'(resp0_valid), '0);
        chk({tag, ".resp1_valid"}, W'(resp1_valid), '0);
        chk({tag, ".resp_data"},   resp_data,       '0);
        chk({tag, ".alu_rd1"},     alu_rd1,         '0);
        chk({tag, ".alu_rd2"},     alu_rd2,         '0);
        chk({tag, ".alu_op"},      W'(alu_op),      '0);
    endtask

    task automatic applyStimulus();
        logic [3:0] ops [5];
        ops[0] = 4'b0000; ops[1] = 4'b0001; ops[2] = 4'b0100; ops[3] = 4'b0110; ops[4] = 4'b0111;

        // Reset values, observed before any clock edge.
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        model_reset();
        #3;
        check_all_zero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single add from requester 0.
        drive(1, 4'b0000, 5, 7, 0, 0, 0, 0, 1);
        step("single.accept");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step("single.exec");
        chk("single.rd1", alu_rd1, 5);
        step("single.resp");
        step("single.idle");

        // Both requesters valid every cycle: grants alternate.
        for (int i = 0; i < 12; i++) begin
            drive(1, ops[i % 5], W'(i * 3 + 1), W'(i + 2), 1, ops[(i + 2) % 5], W'(i * 7), W'(5), 1);
            step($sformatf("contend%0d", i));
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (3) step("contend.drain");

        // Requester 1 AND under five cycles of backpressure.
        drive(0, 0, 0, 0, 1, 4'b0111, 32'hF0, 32'h3C, 0);
        step("bp.accept");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("bp.exec");
        for (int i = 0; i < 5; i++) begin
            drive(1, 4'b0000, 1, 1, 1, 4'b0000, 2, 2, 0);
            step($sformatf("bp.hold%0d", i));
            chk("bp.data", resp_data, 32'h30);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step("bp.release");
        step("bp.idle");

        // Operand change after acceptance must not leak into the result.
        drive(1, 4'b0100, 32'hFF, 32'h0F, 0, 0, 0, 0, 1);
        step("opchg.accept");
        drive(1, 4'b0100, 32'h00, 32'h0F, 0, 0, 0, 0, 1);
        step("opchg.exec");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        step("opchg.resp");
        step("opchg.idle");

        // Fairness: requester 1 waits through requester 0's operation, then wins.
        drive(1, 4'b0000, 10, 20, 0, 0, 0, 0, 1);
        step("fair.accept0");
        drive(1, 4'b0001, 9, 4, 1, 4'b0110, 32'h11, 32'h22, 1);
        step("fair.exec0");
        step("fair.resp0");
        step("fair.grant1");
        chk("fair.owner", W'(dut.gnt_q), W'(1));
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (3) step("fair.drain");

        // Reset asserted in the middle of EXEC.
        drive(1, 4'b0000, 32'h1234, 32'h1111, 0, 0, 0, 0, 1);
        step("rst.accept");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all_zero("rst.mid");
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) step("rst.after");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), ops[$urandom_range(0, 4)], W'($urandom), W'($urandom),
                  1'($urandom_range(0, 1)), ops[$urandom_range(0, 4)], W'($urandom), W'($urandom),
                  1'($urandom_range(0, 2) != 0));
            step($sformatf("rand%0d", i));
        end
    endtask

    initial begin
        applyStimulus();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
